fetch_unit: RTL and testbench

//  Instruction-fetch stage directly upstream of the control unit. Owns the PC,

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_next_pc.sv | 23 ++
 rtl/fetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_unit.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: fetch FSM states, the canonical NOP and the
// opcodes that the control unit also uses.
package fetch_pkg;

  typedef enum logic [1:0] {
    BUBBLE,
    RUN,
    HOLD
  } fetch_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;
  localparam logic [6:0]  OPC_OP_IMM = 7'd19;
  localparam logic [6:0]  OPC_BRANCH = 7'd99;

endpackage

// File: rtl/fetch_next_pc.sv
// Next fetch address: sequential pc+4 or a word-aligned branch target
// computed from the PC of the instruction currently being decoded.
module fetch_next_pc #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [ADDR_WIDTH-1:0] pcd,
  input  logic [ADDR_WIDTH-1:0] immop,
  input  logic                  redirect,
  output logic [ADDR_WIDTH-1:0] next_pc
);

  logic [ADDR_WIDTH-1:0] seq_pc;
  logic [ADDR_WIDTH-1:0] target;

  // Select sequential or branch target; both wrap modulo 2^ADDR_WIDTH.
  always_comb begin
    seq_pc  = pc + ADDR_WIDTH'(4);
    target  = (pcd + immop) & ~ADDR_WIDTH'(3);
    next_pc = redirect ? target : seq_pc;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency instruction
// memory and presents one instruction per cycle with its PC. A NOP is shown
// whenever no valid instruction is present.
// Optional build macro FETCH_PERF_CNT_EN adds fetch_count / squash_count.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  pcsrc,
  input  logic [ADDR_WIDTH-1:0] immop,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_rdata,
  output logic [31:0]           instr,
  output logic                  instr_valid,
  output logic [ADDR_WIDTH-1:0] pc_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           fetch_count,
  output logic [31:0]           squash_count
`endif
);

  fetch_state_t          state, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] pcd_q, pcd_d;
  logic [31:0]           hold_q, hold_d;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic                  redirect;

  // Redirect only when a real instruction is leaving; stall takes priority.
  assign redirect = (state != BUBBLE) && !stall && pcsrc;

  fetch_next_pc #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_next_pc (
    .pc       (pc_q),
    .pcd      (pcd_q),
    .immop    (immop),
    .redirect (redirect),
    .next_pc  (next_pc)
  );

  assign imem_addr = pc_q;
  assign pc_out    = pcd_q;

  // State and PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= BUBBLE;
      pc_q   <= RESET_PC;
      pcd_q  <= RESET_PC;
      hold_q <= INSTR_NOP;
    end else begin
      state  <= state_d;
      pc_q   <= pc_d;
      pcd_q  <= pcd_d;
      hold_q <= hold_d;
    end
  end

  // Next-state logic and instruction output mux.
  always_comb begin
    state_d     = state;
    pc_d        = pc_q;
    pcd_d       = pcd_q;
    hold_d      = hold_q;
    instr       = INSTR_NOP;
    instr_valid = 1'b0;
    case (state)
      BUBBLE: begin
        pcd_d   = pc_q;
        pc_d    = next_pc;
        state_d = RUN;
      end
      RUN, HOLD: begin
        instr       = (state == RUN) ? imem_rdata : hold_q;
        instr_valid = 1'b1;
        if (stall) begin
          // Capture the word only on entry; memory keeps reading pc_q meanwhile.
          if (state == RUN) hold_d = imem_rdata;
          state_d = HOLD;
        end else if (pcsrc) begin
          pc_d    = next_pc;
          state_d = BUBBLE;
        end else begin
          pcd_d   = pc_q;
          pc_d    = next_pc;
          state_d = RUN;
        end
      end
      default: state_d = BUBBLE;
    endcase
  end

`ifdef FETCH_PERF_CNT_EN
  // Performance counters: delivered instructions and taken redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count  <= '0;
      squash_count <= '0;
    end else begin
      if (instr_valid && !stall && !pcsrc) fetch_count <= fetch_count + 32'd1;
      if (redirect) squash_count <= squash_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. Two instances: RESET_PC=0 and a
// wrap-around instance at RESET_PC=FFFF_FFFC. Memory model returns the
// word address as data, so a valid instr must equal its pc_out.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall, pcsrc;
  logic [31:0] immop;
  logic [31:0] addr_a, rdata_a, instr_a, pc_a;
  logic [31:0] addr_b, rdata_b, instr_b, pc_b;
  logic        valid_a, valid_b;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fc_a, sc_a, fc_b, sc_b;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rdata_a <= addr_a;
    rdata_b <= addr_b;
  end

  fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'h0000_0000)) dut_a (
    .clk(clk), .rst(rst), .stall(stall), .pcsrc(pcsrc), .immop(immop),
    .imem_addr(addr_a), .imem_rdata(rdata_a), .instr(instr_a),
    .instr_valid(valid_a), .pc_out(pc_a)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fc_a), .squash_count(sc_a)
`endif
  );

  fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .rst(rst), .stall(stall), .pcsrc(pcsrc), .immop(immop),
    .imem_addr(addr_b), .imem_rdata(rdata_b), .instr(instr_b),
    .instr_valid(valid_b), .pc_out(pc_b)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fc_b), .squash_count(sc_b)
`endif
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic        pcsrc;
    logic [31:0] immop;
    logic        valid;
    logic [31:0] pc;
    logic        chk_pc;
    logic        chk_addr;
    logic [31:0] addr;
  } vec_t;

  typedef struct {
    bit          dut_b;
    logic        valid;
    logic [31:0] pc;
    logic        chk_pc;
    logic        chk_addr;
    logic [31:0] addr;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  vec_t tbl[27];

  function automatic vec_t mk(logic r, logic s, logic p, logic [31:0] imm,
                              logic v, logic [31:0] pc, logic cp,
                              logic ca, logic [31:0] a);
    vec_t t;
    t.rst = r; t.stall = s; t.pcsrc = p; t.immop = imm;
    t.valid = v; t.pc = pc; t.chk_pc = cp; t.chk_addr = ca; t.addr = a;
    return t;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a falling edge: drive inputs, check outputs, advance a cycle.
  task automatic step(input vec_t v, input bit use_b, input string tag);
    exp_t e, got;
    logic [31:0] act_instr, act_pc, act_addr;
    logic        act_valid;
    rst = v.rst; stall = v.stall; pcsrc = v.pcsrc; immop = v.immop;
    e.dut_b = use_b; e.valid = v.valid; e.pc = v.pc; e.chk_pc = v.chk_pc;
    e.chk_addr = v.chk_addr; e.addr = v.addr; e.tag = tag;
    sb.push_back(e);
    #1;
    got = sb.pop_front();
    act_valid = got.dut_b ? valid_b : valid_a;
    act_instr = got.dut_b ? instr_b : instr_a;
    act_pc    = got.dut_b ? pc_b    : pc_a;
    act_addr  = got.dut_b ? addr_b  : addr_a;
    cmp({got.tag, " valid"}, {31'd0, act_valid}, {31'd0, got.valid});
    cmp({got.tag, " instr"}, act_instr, got.valid ? got.pc : INSTR_NOP);
    if (got.chk_pc)   cmp({got.tag, " pc_out"}, act_pc, got.pc);
    if (got.chk_addr) cmp({got.tag, " imem_addr"}, act_addr, got.addr);
    @(negedge clk);
  endtask

  initial begin
    //            rst s p immop          v  pc            cp ca addr
    tbl[0]  = mk(0, 0, 0, 32'd0,          0, 32'd0,         1, 1, 32'd0);
    tbl[1]  = mk(0, 0, 0, 32'd0,          1, 32'd0,         1, 1, 32'd4);
    tbl[2]  = mk(0, 0, 0, 32'd0,          1, 32'd4,         1, 0, 32'd0);
    tbl[3]  = mk(0, 0, 0, 32'd0,          1, 32'd8,         1, 0, 32'd0);
    tbl[4]  = mk(0, 0, 1, 32'hFFFF_FFFC,  1, 32'd12,        1, 0, 32'd0);
    tbl[5]  = mk(0, 0, 1, 32'd100,        0, 32'd0,         0, 1, 32'd8);
    tbl[6]  = mk(0, 0, 1, 32'hFFFF_FFF8,  1, 32'd8,         1, 0, 32'd0);
    tbl[7]  = mk(0, 0, 0, 32'd0,          0, 32'd0,         0, 1, 32'd0);
    tbl[8]  = mk(0, 0, 0, 32'd0,          1, 32'd0,         1, 0, 32'd0);
    tbl[9]  = mk(0, 1, 0, 32'd0,          1, 32'd4,         1, 0, 32'd0);
    tbl[10] = mk(0, 1, 0, 32'd0,          1, 32'd4,         1, 1, 32'd8);
    tbl[11] = mk(0, 1, 0, 32'd0,          1, 32'd4,         1, 0, 32'd0);
    tbl[12] = mk(0, 0, 0, 32'd0,          1, 32'd4,         1, 0, 32'd0);
    tbl[13] = mk(0, 0, 0, 32'd0,          1, 32'd8,         1, 0, 32'd0);
    tbl[14] = mk(0, 1, 1, 32'd16,         1, 32'd12,        1, 0, 32'd0);
    tbl[15] = mk(0, 1, 1, 32'd16,         1, 32'd12,        1, 1, 32'd16);
    tbl[16] = mk(0, 0, 1, 32'd16,         1, 32'd12,        1, 0, 32'd0);
    tbl[17] = mk(0, 0, 0, 32'd0,          0, 32'd0,         0, 1, 32'd28);
    tbl[18] = mk(0, 0, 0, 32'd0,          1, 32'd28,        1, 0, 32'd0);
    tbl[19] = mk(0, 0, 1, 32'd7,          1, 32'd32,        1, 0, 32'd0);
    tbl[20] = mk(0, 0, 0, 32'd0,          0, 32'd0,         0, 1, 32'd36);
    tbl[21] = mk(0, 0, 0, 32'd0,          1, 32'd36,        1, 0, 32'd0);
    tbl[22] = mk(0, 1, 0, 32'd0,          1, 32'd40,        1, 0, 32'd0);
    tbl[23] = mk(1, 1, 0, 32'd0,          1, 32'd40,        1, 1, 32'd44);
    tbl[24] = mk(0, 1, 1, 32'd64,         0, 32'd0,         1, 1, 32'd0);
    tbl[25] = mk(0, 0, 0, 32'd0,          1, 32'd0,         1, 0, 32'd0);
    tbl[26] = mk(0, 0, 0, 32'd0,          1, 32'd4,         1, 0, 32'd0);

    rst = 1'b1; stall = 1'b0; pcsrc = 1'b0; immop = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < 27; i++) step(tbl[i], 1'b0, $sformatf("vec%0d", i));

    // Wrap-around instance: PC FFFF_FFFC -> 0, misaligned offset gets cleared.
    rst = 1'b1; stall = 1'b0; pcsrc = 1'b0; immop = '0;
    @(negedge clk);
    step(mk(0, 0, 0, 32'd0, 0, 32'hFFFF_FFFC, 1, 1, 32'hFFFF_FFFC), 1'b1, "wrap0");
    step(mk(0, 0, 0, 32'd0, 1, 32'hFFFF_FFFC, 1, 1, 32'd0),         1'b1, "wrap1");
    step(mk(0, 0, 1, 32'd6, 1, 32'd0,         1, 0, 32'd0),         1'b1, "wrap2");
    step(mk(0, 0, 0, 32'd0, 0, 32'd0,         0, 1, 32'd4),         1'b1, "wrap3");
    step(mk(0, 0, 0, 32'd0, 1, 32'd4,         1, 0, 32'd0),         1'b1, "wrap4");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
